// File: rtl/pe_array_pkg.sv
// Shared defaults, feeder FSM state type and a width helper for the PE_array input-stream feeder.
package pe_array_pkg;

    localparam int DEF_DATA_W     = 27;
    localparam int PSUM_W         = 32;
    localparam int DEF_ROW_LENGTH = 11;
    localparam int DEF_O_CH       = 8;
    localparam int DEF_K          = 10;
    localparam int DEF_DRAIN      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } feeder_state_t;

    // Degenerate sizes (one entry) still need a 1-bit counter or address.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_feed_addr_gen.sv
// Walks slot/group counters and issues one SRAM read per cycle: O_CH weight reads, then one activation read per group.
module pe_feed_addr_gen
    import pe_array_pkg::*;
#(
    parameter int O_CH   = DEF_O_CH,
    parameter int GROUPS = DEF_ROW_LENGTH * DEF_K,
    parameter int WA_W   = clog2_min1(DEF_O_CH * DEF_ROW_LENGTH * DEF_K),
    parameter int AA_W   = clog2_min1(DEF_ROW_LENGTH * DEF_K)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            kick,
    output logic            w_rd_en,
    output logic [WA_W-1:0] w_rd_addr,
    output logic            a_rd_en,
    output logic [AA_W-1:0] a_rd_addr,
    output logic            last
);

    localparam int SW = clog2_min1(O_CH + 1);
    localparam int GW = clog2_min1(GROUPS);

    logic          running;
    logic [SW-1:0] slot;
    logic [GW-1:0] group;
    logic          at_act;

    always_comb begin
        at_act    = (slot == SW'(O_CH));
        last      = running && at_act && (group == GW'(GROUPS - 1));
        w_rd_en   = running && !at_act;
        a_rd_en   = running && at_act;
        w_rd_addr = w_rd_en ? (WA_W'(group) * WA_W'(O_CH) + WA_W'(slot)) : '0;
        a_rd_addr = a_rd_en ? AA_W'(group) : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            running <= 1'b0;
            slot    <= '0;
            group   <= '0;
        end else if (kick) begin
            running <= 1'b1;
            slot    <= '0;
            group   <= '0;
        end else if (running) begin
            if (last) begin
                running <= 1'b0;
                slot    <= '0;
                group   <= '0;
            end else if (at_act) begin
                slot    <= '0;
                group   <= group + 1'b1;
            end else begin
                slot    <= slot + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_array_feeder.sv
// Streams interleaved weight/activation words into PE_array, waits for the pipeline drain, then opens the psum window.
module pe_array_feeder
    import pe_array_pkg::*;
#(
    parameter int K          = DEF_K,
    parameter int ROW_LENGTH = DEF_ROW_LENGTH,
    parameter int O_CH       = DEF_O_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DRAIN      = DEF_DRAIN,
    localparam int GROUPS    = ROW_LENGTH * K,
    localparam int WA_W      = clog2_min1(O_CH * GROUPS),
    localparam int AA_W      = clog2_min1(GROUPS),
    localparam int PI_W      = clog2_min1(O_CH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [WA_W-1:0]   w_rd_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    output logic              a_rd_en,
    output logic [AA_W-1:0]   a_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              psum_valid,
    output logic [PI_W-1:0]   psum_idx,
    output feeder_state_t     fsm_state
);

    localparam int DC_W = clog2_min1(DRAIN);

    feeder_state_t   state, state_next;
    logic            kick;
    logic            issue_last;
    logic            p1_valid, p1_act, p1_last;
    logic            out_last;
    logic [DC_W-1:0] drain_cnt;
    logic [PI_W-1:0] res_cnt;

    pe_feed_addr_gen #(
        .O_CH   (O_CH),
        .GROUPS (GROUPS),
        .WA_W   (WA_W),
        .AA_W   (AA_W)
    ) u_addr_gen (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .kick      (kick),
        .w_rd_en   (w_rd_en),
        .w_rd_addr (w_rd_addr),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .last      (issue_last)
    );

    always_comb begin
        state_next = state;
        kick       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                    kick       = 1'b1;
                end
            end
            ST_FETCH:  state_next = ST_STREAM;
            ST_STREAM: if (data_out_valid && out_last) state_next = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == DC_W'(DRAIN - 1)) state_next = ST_RESULT;
            ST_RESULT: if (res_cnt == PI_W'(O_CH - 1)) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Read data arrives one cycle after the enable; the pipe tags which SRAM to pick and where the stream ends.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            p1_valid       <= 1'b0;
            p1_act         <= 1'b0;
            p1_last        <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            out_last       <= 1'b0;
            drain_cnt      <= '0;
            res_cnt        <= '0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            p1_valid       <= w_rd_en | a_rd_en;
            p1_act         <= a_rd_en;
            p1_last        <= issue_last;
            data_out       <= !p1_valid ? '0 : (p1_act ? a_rd_data : w_rd_data);
            data_out_valid <= p1_valid;
            out_last       <= p1_last;
            drain_cnt      <= (state == ST_DRAIN && state_next == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            res_cnt        <= (state == ST_RESULT && state_next == ST_RESULT) ? res_cnt + 1'b1 : '0;
            done           <= (state == ST_RESULT) && (state_next == ST_IDLE);
        end
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        psum_valid = (state == ST_RESULT);
        psum_idx   = psum_valid ? res_cnt : '0;
        fsm_state  = state;
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Random-content SRAM bench: expected stream/psum/done timeline is queued at start and checked by a negedge monitor.
module tb_pe_array_feeder;
    import pe_array_pkg::*;

    localparam int O_CH = 8, K = 10, ROW_LENGTH = 11, DRAIN = 3, DATA_W = 27;
    localparam int GROUPS  = ROW_LENGTH * K;
    localparam int N_WORDS = (O_CH + 1) * GROUPS;
    localparam int WA_W = $clog2(O_CH * GROUPS), AA_W = $clog2(GROUPS), PI_W = $clog2(O_CH);

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_in, start, start1;
    logic busy, done, w_rd_en, a_rd_en, data_out_valid, psum_valid;
    logic [WA_W-1:0] w_rd_addr;
    logic [AA_W-1:0] a_rd_addr;
    logic [DATA_W-1:0] w_rd_data, a_rd_data, data_out;
    logic [PI_W-1:0] psum_idx;
    feeder_state_t fsm_state;

    logic busy1, done1, w1_rd_en, a1_rd_en, dv1, pv1;
    logic [0:0] w1_rd_addr, a1_rd_addr, pidx1;
    logic [DATA_W-1:0] w1_rd_data, a1_rd_data, dout1;
    feeder_state_t fsm_state1;

    pe_array_feeder dut (
        .clk_in(clk), .rst_in(rst_in), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .psum_valid(psum_valid), .psum_idx(psum_idx), .fsm_state(fsm_state)
    );

    pe_array_feeder #(.K(1), .ROW_LENGTH(1), .O_CH(1)) dut1 (
        .clk_in(clk), .rst_in(rst_in), .start(start1), .busy(busy1), .done(done1),
        .w_rd_en(w1_rd_en), .w_rd_addr(w1_rd_addr), .w_rd_data(w1_rd_data),
        .a_rd_en(a1_rd_en), .a_rd_addr(a1_rd_addr), .a_rd_data(a1_rd_data),
        .data_out(dout1), .data_out_valid(dv1),
        .psum_valid(pv1), .psum_idx(pidx1), .fsm_state(fsm_state1)
    );

    // SRAM models: junk on the data bus whenever no read was issued
    logic [DATA_W-1:0] w_mem [O_CH*GROUPS];
    logic [DATA_W-1:0] a_mem [GROUPS];
    logic [DATA_W-1:0] w1_mem, a1_mem;

    always @(posedge clk) begin
        w_rd_data  <= w_rd_en  ? w_mem[w_rd_addr] : DATA_W'($urandom);
        a_rd_data  <= a_rd_en  ? a_mem[a_rd_addr] : DATA_W'($urandom);
        w1_rd_data <= w1_rd_en ? w1_mem : DATA_W'($urandom);
        a1_rd_data <= a1_rd_en ? a1_mem : DATA_W'($urandom);
    end

    // scoreboard state
    int checks = 0, failures = 0;
    bit mon_en = 1'b0;
    int busy_lo = 1, busy_hi = 0;
    logic [DATA_W-1:0] exp_q[$];
    int exp_cyc[$];
    int ps_idx_q[$];
    int ps_cyc[$];
    int done_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic randomize_mems();
        for (int i = 0; i < O_CH * GROUPS; i++) w_mem[i] = DATA_W'($urandom);
        for (int i = 0; i < GROUPS; i++) a_mem[i] = DATA_W'($urandom);
        w1_mem = DATA_W'($urandom);
        a1_mem = DATA_W'($urandom);
    endtask

    // Reference model: a run started at edge e yields word i at cycle e+2+i, then DRAIN idle
    // cycles, O_CH psum cycles, and done one cycle later. Called at posedge+1.
    task automatic issue_start();
        int e;
        int g, s;
        e = cyc + 1;
        start = 1'b1;
        if (e - 1 > busy_hi) begin
            for (int i = 0; i < N_WORDS; i++) begin
                g = i / (O_CH + 1);
                s = i % (O_CH + 1);
                exp_q.push_back((s < O_CH) ? w_mem[g * O_CH + s] : a_mem[g]);
                exp_cyc.push_back(e + 2 + i);
            end
            for (int j = 0; j < O_CH; j++) begin
                ps_idx_q.push_back(j);
                ps_cyc.push_back(e + N_WORDS + 2 + DRAIN + j);
            end
            done_cyc.push_back(e + N_WORDS + 2 + DRAIN + O_CH);
            busy_lo = e;
            busy_hi = e + N_WORDS + DRAIN + O_CH + 1;
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc < target && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("wait_reached", cyc, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, data_out_valid, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_w_rd_en"}, w_rd_en, 0);
        check({tag, "_a_rd_en"}, a_rd_en, 0);
        check({tag, "_w_addr"}, w_rd_addr, 0);
        check({tag, "_a_addr"}, a_rd_addr, 0);
        check({tag, "_psum_valid"}, psum_valid, 0);
        check({tag, "_psum_idx"}, psum_idx, 0);
        check({tag, "_state"}, fsm_state, ST_IDLE);
    endtask

    // Reset mid-stream: everything already on the outputs this cycle stays expected, later events are dropped.
    task automatic do_reset();
        int c;
        c = cyc;
        rst_in = 1'b1;
        while (exp_cyc.size() > 0 && exp_cyc[$] > c) begin
            void'(exp_q.pop_back());
            void'(exp_cyc.pop_back());
        end
        while (ps_cyc.size() > 0 && ps_cyc[$] > c) begin
            void'(ps_idx_q.pop_back());
            void'(ps_cyc.pop_back());
        end
        while (done_cyc.size() > 0 && done_cyc[$] > c) void'(done_cyc.pop_back());
        busy_hi = c;
        @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");
        repeat (3) begin
            @(negedge clk);
            check("no_read_after_reset", w_rd_en | a_rd_en, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_out_valid === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected_word", data_out_valid, 0);
                else begin
                    check("stream_word", data_out, exp_q.pop_front());
                    check("stream_cycle", cyc, exp_cyc.pop_front());
                end
            end else begin
                check("idle_data_zero", data_out, 0);
                if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
                    check("missing_word", data_out_valid, 1);
                    void'(exp_q.pop_front());
                    void'(exp_cyc.pop_front());
                end
            end
            if (psum_valid === 1'b1) begin
                if (ps_cyc.size() == 0) check("unexpected_psum", psum_valid, 0);
                else begin
                    check("psum_idx", psum_idx, ps_idx_q.pop_front());
                    check("psum_cycle", cyc, ps_cyc.pop_front());
                end
            end else begin
                check("psum_idx_idle", psum_idx, 0);
                if (ps_cyc.size() > 0 && ps_cyc[0] <= cyc) begin
                    check("missing_psum", psum_valid, 1);
                    void'(ps_idx_q.pop_front());
                    void'(ps_cyc.pop_front());
                end
            end
            if (done === 1'b1) begin
                if (done_cyc.size() == 0) check("unexpected_done", done, 0);
                else check("done_cycle", cyc, done_cyc.pop_front());
            end else if (done_cyc.size() > 0 && done_cyc[0] <= cyc) begin
                check("missing_done", done, 1);
                void'(done_cyc.pop_front());
            end
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            check("rd_en_exclusive", w_rd_en & a_rd_en, 0);
        end
    end

    // stimulus
    initial begin
        int e1, t, e_a;
        rst_in = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        randomize_mems();
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_deg_busy", busy1, 0);
        check("reset_deg_valid", dv1, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        repeat ($urandom_range(1, 5)) begin
            @(posedge clk);
            #1;
        end

        issue_start();
        e_a = busy_lo;
        wait_until(e_a + 2 + 100);
        issue_start();
        wait_until(busy_hi + 1);
        issue_start();

        wait_until(busy_lo + 2 + 500);
        do_reset();

        repeat ($urandom_range(2, 8)) begin
            @(posedge clk);
            #1;
        end
        randomize_mems();
        issue_start();
        wait_until(busy_hi + 4);
        check("leftover_words", exp_q.size(), 0);
        check("leftover_psum", ps_cyc.size(), 0);
        check("leftover_done", done_cyc.size(), 0);

        e1 = cyc + 1;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            t = cyc - e1;
            check("deg_valid", dv1, (t == 2 || t == 3));
            check("deg_data", dout1, (t == 2) ? w1_mem : ((t == 3) ? a1_mem : '0));
            check("deg_psum_valid", pv1, (t == 7));
            check("deg_psum_idx", pidx1, 0);
            check("deg_done", done1, (t == 8));
            check("deg_busy", busy1, (t >= 0 && t <= 7));
            check("deg_addr", {w1_rd_addr, a1_rd_addr}, 0);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
